// File: rtl/sram_ctrl.sv
// sram_ctrl: single-outstanding asynchronous SRAM controller for the MEM-stage data port.
// Every SRAM pin is a register loaded on FSM transitions; CPU inputs never reach a pin combinationally.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

    // Word-aligned, and upper bits alias by design.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_o     <= 1'b0;
            data_o      <= '0;
            sram_addr_o <= '0;
            sram_dq_o   <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_be_n_o <= 4'b1111;
        end else begin
            ready_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ce_i) begin
                        sram_addr_o <= addr_i[ADDR_W+1:2];
                        sram_ce_n_o <= 1'b0;
                        if (we_i) begin
                            sram_dq_o   <= data_i;
                            sram_dq_oe  <= 1'b1;
                            sram_be_n_o <= ~sel_i;
                            state       <= WR_SETUP;
                        end else begin
                            sram_oe_n_o <= 1'b0;
                            sram_be_n_o <= 4'b0000;
                            cnt         <= CNT_LOAD;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        data_o      <= sram_dq_i;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_be_n_o <= 4'b1111;
                        ready_o     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n_o <= 1'b0;
                    cnt         <= CNT_LOAD;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        sram_we_n_o <= 1'b1;
                        state       <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    sram_ce_n_o <= 1'b1;
                    sram_dq_oe  <= 1'b0;
                    sram_be_n_o <= 4'b1111;
                    ready_o     <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    // ce_i here still belongs to the finished request.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed transactions with per-cycle pin checks and a
// ready-driven scoreboard monitor for data_o.
module tb_sram_ctrl;

    localparam int WC = 2;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce_i = 1'b0;
    logic          we_i = 1'b0;
    logic [31:0]   addr_i = '0;
    logic [3:0]    sel_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   data_o;
    logic          ready_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_dq_i;
    logic [31:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [3:0]    sram_be_n_o;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] sb[$];
    logic [31:0] last_rd = '0;
    logic [31:0] mon_exp;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(WC), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .ce_i(ce_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .sel_i(sel_i),
        .data_i(data_i),
        .data_o(data_o),
        .ready_o(ready_o),
        .sram_addr_o(sram_addr_o),
        .sram_dq_i(sram_dq_i),
        .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_ce_n_o(sram_ce_n_o),
        .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o),
        .sram_be_n_o(sram_be_n_o)
    );

    // SRAM model: byte-laned write while ce_n and we_n are low.
    assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b])
                    mem[sram_addr_o[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready_o) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ready_o: got unexpected pulse, expected none");
            end else begin
                mon_exp = sb.pop_front();
                if (data_o !== mon_exp) begin
                    n_fail++;
                    $display("FAIL data_o: got %h expected %h", data_o, mon_exp);
                end
            end
        end
    end

    // One request; leaves ce_i high after DONE unless drop is set.
    task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd, input bit drop);
        int total;
        logic [8:0] exp_pins;
        logic ex_ce_n, ex_oe_n, ex_we_n, ex_oe;
        logic [3:0] ex_be;
        total = we ? WC + 3 : WC + 1;
        @(posedge clk);
        #1;
        ce_i = 1'b1; we_i = we; addr_i = a; sel_i = s; data_i = d;
        if (!we) last_rd = exp_rd;
        sb.push_back(last_rd);
        @(negedge clk);
        chk("idle pins c0", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe, ready_o}, 5'b11100);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            ex_ce_n = !(c < total);
            ex_oe_n = !(!we && c <= WC);
            ex_we_n = !(we && c >= 2 && c <= WC + 1);
            ex_oe   = we && c <= WC + 2;
            ex_be   = (c < total) ? (we ? ~s : 4'b0000) : 4'b1111;
            exp_pins = {ex_ce_n, ex_oe_n, ex_we_n, ex_oe, ex_be, c == total};
            chk($sformatf("pins c%0d", c),
                {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe, sram_be_n_o, ready_o}, exp_pins);
            if (c < total) chk($sformatf("addr c%0d", c), sram_addr_o, a[AW+1:2]);
            if (ex_oe) chk($sformatf("dq_o c%0d", c), sram_dq_o, d);
            if (drop && c == 1) ce_i = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        ce_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    localparam logic [92:0] RST_VEC = {1'b0, 32'h0, 20'h0, 32'h0, 1'b0, 3'b111, 4'b1111};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ce_i = 1'($urandom); we_i = 1'($urandom);
            addr_i = $urandom; sel_i = 4'($urandom); data_i = $urandom;
            @(negedge clk);
            chk($sformatf("reset outputs %0d", i),
                {ready_o, data_o, sram_addr_o, sram_dq_o, sram_dq_oe,
                 sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, RST_VEC);
        end
        ce_i = 1'b0;
        rst = 1'b1;

        txn(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        idle(1);
        chk("mem full write", mem[4], 32'hDEAD_BEEF);

        txn(1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0, 1'b0);
        idle(1);
        txn(1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
        idle(1);
        chk("mem byte write", mem[8], 32'h1122_AB44);

        txn(1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
        idle(1);
        txn(1'b0, 32'h0000_0013, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);
        idle(2);

        txn(1'b0, 32'hFFC0_0012, 4'b0000, 32'h0, 32'h1234_5678, 1'b0);
        idle(1);

        txn(1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        idle(1);
        chk("mem sel0 write", mem[8], 32'h1122_AB44);

        txn(1'b1, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        idle(1);

        txn(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b1);
        idle(1);

        @(posedge clk);
        #1;
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; sel_i = 4'hF; data_i = 32'h55;
        repeat (3) @(negedge clk);
        chk("we_n low before reset", sram_we_n_o, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("reset mid-write", {ready_o, data_o, sram_addr_o, sram_dq_o, sram_dq_oe,
            sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, RST_VEC);
        ce_i = 1'b0;
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        chk("mem after abort", mem[12], 32'h0);
        rst = 1'b1;

        txn(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        idle(4);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
